// File: rtl/sram_axi_bridge_pkg.sv
// Shared FSM encoding, AXI3 single-beat constants and default transaction IDs for the SRAM-to-AXI bridge.
// Pure definitions; no latency or backpressure of its own.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AWW,
        WR_B
    } bridgeState_t;

    localparam logic [3:0] LEN0       = 4'd0;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [3:0] INST_ID = 4'd0;
    localparam logic [3:0] DATA_ID = 4'd1;

    // kseg0/kseg1 translation plus forced word alignment
    function automatic logic [31:0] toPaddr(input logic [31:0] vaddr, input logic [31:0] mask);
        return {vaddr[31:2] & mask[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_axi_wr_chan.sv
// Drives the AW/W valid pair for one write; each side drops on its own handshake and records a done bit.
// done rises the cycle after the later handshake; a channel stalls only itself while its ready is low.
module axi_wr_chan (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic done
);

    logic awDone;
    logic wDone;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
        end else if (start) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                awvalid <= 1'b0;
                awDone  <= 1'b1;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
                wDone  <= 1'b1;
            end
        end
    end

    assign done = awDone & wDone;

endmodule

// File: rtl/sram_axi_bridge.sv
// Serves the core's SRAM-style fetch and data ports with single-beat AXI3 transactions, data port first.
// Min read 3 cycles request-to-unstall; mem_stall holds the pipeline until every active request is served.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0]  INST_ID = sram_axi_bridge_pkg::INST_ID,
    parameter logic [3:0]  DATA_ID = sram_axi_bridge_pkg::DATA_ID,
    parameter logic [31:0] PA_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    bridgeState_t state;
    logic         instOk;
    logic         dataOk;
    logic         reqIsData;
    logic [3:0]   reqId;
    logic [31:0]  reqAddr;
    logic [3:0]   reqWen;
    logic [31:0]  reqWdata;
    logic         wrStart;
    logic         wrDone;

    assign mem_stall = (inst_en & ~instOk) | (data_en & ~dataOk);
    assign wrStart   = (state == IDLE) && data_en && !dataOk && (data_wen != 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            instOk     <= 1'b0;
            dataOk     <= 1'b0;
            reqIsData  <= 1'b0;
            reqId      <= 4'd0;
            reqAddr    <= 32'd0;
            reqWen     <= 4'd0;
            reqWdata   <= 32'd0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            // completion below overrides this clear if both land on one edge
            if (!mem_stall) begin
                instOk <= 1'b0;
                dataOk <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (data_en && !dataOk) begin
                        reqIsData <= 1'b1;
                        reqId     <= DATA_ID;
                        reqAddr   <= toPaddr(data_addr, PA_MASK);
                        reqWen    <= data_wen;
                        reqWdata  <= data_wdata;
                        if (data_wen != 4'b0000) begin
                            state <= WR_AWW;
                        end else begin
                            state   <= RD_AR;
                            arvalid <= 1'b1;
                        end
                    end else if (inst_en && !instOk) begin
                        reqIsData <= 1'b0;
                        reqId     <= INST_ID;
                        reqAddr   <= toPaddr(inst_addr, PA_MASK);
                        reqWen    <= 4'b0000;
                        state     <= RD_AR;
                        arvalid   <= 1'b1;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                        if (reqIsData) begin
                            data_rdata <= rdata;
                            dataOk     <= 1'b1;
                        end else begin
                            inst_rdata <= rdata;
                            instOk     <= 1'b1;
                        end
                    end
                end
                WR_AWW: begin
                    if (wrDone) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        dataOk <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi_wr_chan u_wrChan (
        .clk     (clk),
        .rst     (rst),
        .start   (wrStart),
        .awready (awready),
        .wready  (wready),
        .awvalid (awvalid),
        .wvalid  (wvalid),
        .done    (wrDone)
    );

    assign arid    = reqId;
    assign araddr  = reqAddr;
    assign arlen   = LEN0;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign awid    = reqId;
    assign awaddr  = reqAddr;
    assign awlen   = LEN0;
    assign awsize  = SIZE_WORD;
    assign awburst = BURST_INCR;
    assign wdata   = reqWdata;
    assign wstrb   = reqWen;
    assign wlast   = wvalid;

endmodule
